// File: rtl/peripheral_tx.sv
// Mailbox-draining serial transmitter: each new PeripheralBuffer word is sent as
// two 8N1 frames, low byte first. Only the most recent unsent word is kept.
// state | meaning
// IDLE  | line high, waiting for a pending word
// START | start bit (low)
// DATA  | data bits, LSB first
// STOP  | stop bit (high); chains once into the high-byte frame
module peripheral_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*DATA_WIDTH-1:0] PeripheralBuffer,
    input  logic                    clearOverrun,
    output logic                    txd,
    output logic                    busy,
    output logic                    overrun
);

    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                  r_state;
    logic [WORD_W-1:0]       r_last_seen;
    logic [WORD_W-1:0]       r_pend_word;
    logic                    r_pending;
    logic                    r_overrun;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_hi_byte;
    logic                    r_byte_sel;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [BAUD_W-1:0]       r_baud_cnt;
    logic                    r_txd;
    logic                    r_busy;

    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   w_shift_nxt;
    logic [DATA_WIDTH-1:0]   w_hi_nxt;
    logic                    w_sel_nxt;
    logic [BIT_W-1:0]        w_bit_nxt;
    logic [BAUD_W-1:0]       w_baud_nxt;
    logic                    w_txd_nxt;
    logic                    w_busy_nxt;
    logic                    w_consume;
    logic                    w_change;
    logic                    w_baud_tc;

    assign w_change  = (PeripheralBuffer != r_last_seen);
    assign w_baud_tc = (r_baud_cnt == '0);

    // A change in the same cycle as a consume re-arms pending without flagging
    // overrun, since the previous word has just been taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_seen <= '0;
            r_pend_word <= '0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_change) begin
                r_last_seen <= PeripheralBuffer;
                r_pend_word <= PeripheralBuffer;
                r_pending   <= 1'b1;
            end else if (w_consume) begin
                r_pending   <= 1'b0;
            end
            if (w_change && r_pending && !w_consume) begin
                r_overrun <= 1'b1;
            end else if (clearOverrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_hi_byte  <= '0;
            r_byte_sel <= 1'b0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_hi_byte  <= w_hi_nxt;
            r_byte_sel <= w_sel_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_hi_nxt    = r_hi_byte;
        w_sel_nxt   = r_byte_sel;
        w_bit_nxt   = r_bit_cnt;
        w_baud_nxt  = r_baud_cnt;
        w_consume   = 1'b0;
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_consume   = 1'b1;
                    w_shift_nxt = r_pend_word[DATA_WIDTH-1:0];
                    w_hi_nxt    = r_pend_word[WORD_W-1:DATA_WIDTH];
                    w_sel_nxt   = 1'b0;
                    w_baud_nxt  = BAUD_LOAD;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_tc) begin
                    w_baud_nxt  = BAUD_LOAD;
                    w_bit_nxt   = BIT_LOAD;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_tc) begin
                    w_baud_nxt = BAUD_LOAD;
                    if (r_bit_cnt == '0) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_bit_nxt   = r_bit_cnt - BIT_W'(1);
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt - BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_tc) begin
                    if (!r_byte_sel) begin
                        w_shift_nxt = r_hi_byte;
                        w_sel_nxt   = 1'b1;
                        w_baud_nxt  = BAUD_LOAD;
                        w_state_nxt = S_START;
                    end else begin
                        w_baud_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt - BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the line moves on the
        // same edge as the state change.
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign txd     = r_txd;
    assign busy    = r_busy;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_peripheral_tx.sv
// Self-checking bench for peripheral_tx: table-driven word frames, hand-written
// corner sequences, and a randomized run against a cycle-level waveform model.
module tb_peripheral_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mbox4, mbox1;
    logic        clear4, clear1;
    logic        txd4, busy4, over4;
    logic        txd1, busy1, over1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    peripheral_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .PeripheralBuffer(mbox4), .clearOverrun(clear4),
        .txd(txd4), .busy(busy4), .overrun(over4));

    peripheral_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .PeripheralBuffer(mbox1), .clearOverrun(clear1),
        .txd(txd1), .busy(busy1), .overrun(over1));

    task automatic check(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (CLKS_PER_BIT=4 instance) ----------------
    localparam int CPB = 4;
    logic [15:0] m_last = '0, m_pend = '0;
    bit          m_pending = 0, m_over = 0;
    int          m_left = 0, m_idx = 0;
    logic [19:0] m_bits = '0;

    // Line waveform of one word, index 0 transmitted first.
    function automatic logic [19:0] frame_bits(input logic [15:0] w);
        logic [19:0] b;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = w[i];
        b[9]  = 1'b1;
        b[10] = 1'b0;
        for (int i = 0; i < 8; i++) b[11+i] = w[8+i];
        b[19] = 1'b1;
        return b;
    endfunction

    always @(posedge clk) begin
        bit consume, change;
        if (!rst_n) begin
            m_last = '0; m_pend = '0; m_pending = 0; m_over = 0; m_left = 0; m_idx = 0;
        end else begin
            consume = (m_left == 0) && m_pending;
            change  = (mbox4 != m_last);
            if (m_left > 0) begin
                m_left--;
                m_idx++;
            end else if (m_pending) begin
                m_bits = frame_bits(m_pend);
                m_left = 20 * CPB;
                m_idx  = 0;
            end
            if (change && m_pending && !consume) m_over = 1;
            else if (clear4) m_over = 0;
            if (change) begin
                m_pending = 1; m_pend = mbox4; m_last = mbox4;
            end else if (consume) begin
                m_pending = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_txd", txd4, (m_left > 0) ? m_bits[m_idx / CPB] : 1'b1);
            check("model_busy", busy4, m_left > 0);
            check("model_overrun", over4, m_over);
        end
    end

    // ---------------- directed helpers ----------------
    // Called at the first negedge with busy high; checks every sample of the word.
    task automatic check_word(input int which, input logic [19:0] seq, input string name);
        int cpb;
        cpb = (which == 1) ? 1 : 4;
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < cpb; c++) begin
                check({name, "_txd"}, (which == 1) ? txd1 : txd4, seq[19-i]);
                check({name, "_busy"}, (which == 1) ? busy1 : busy4, 1'b1);
                @(negedge clk);
            end
        end
        check({name, "_busy_end"}, (which == 1) ? busy1 : busy4, 1'b0);
    endtask

    task automatic wait_idle(input int limit);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < limit) begin
            @(negedge clk);
            n++;
            quiet = busy4 ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", limit);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic [19:0] seq;   // transmitted bits, first bit in the MSB
    } vec_t;

    vec_t vecs[5];

    initial begin
        int hi_cnt, gap;

        vecs[0] = '{16'h12A5, 20'b0_10100101_1_0_01001000_1};
        vecs[1] = '{16'h0002, 20'b0_01000000_1_0_00000000_1};
        vecs[2] = '{16'hFF00, 20'b0_00000000_1_0_11111111_1};
        vecs[3] = '{16'h8001, 20'b0_10000000_1_0_00000001_1};
        vecs[4] = '{16'h5A3C, 20'b0_00111100_1_0_01011010_1};

        rst_n = 1'b0; mbox4 = '0; mbox1 = '0; clear4 = 1'b0; clear1 = 1'b0;

        // Reset
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_txd", txd4, 1'b1);
        check("reset_busy", busy4, 1'b0);
        check("reset_overrun", over4, 1'b0);
        check("reset_txd_cpb1", txd1, 1'b1);
        rst_n = 1'b1;
        hi_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy4 || !txd4) hi_cnt++;
        end
        check_int("reset_no_frame", hi_cnt, 0);

        // Table of single words sent from idle
        foreach (vecs[v]) begin
            mbox4 = vecs[v].word;
            @(negedge clk);
            check("pre_start_busy", busy4, 1'b0);
            check("pre_start_txd", txd4, 1'b1);
            @(negedge clk);
            check_word(0, vecs[v].seq, $sformatf("word_%04h", vecs[v].word));
            check("word_overrun", over4, 1'b0);
            wait_idle(50);
        end

        // Rewrite of identical value: no frame
        mbox4 = vecs[4].word;
        hi_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy4) hi_cnt++;
        end
        check_int("rewrite_no_frame", hi_cnt, 0);

        // Overrun: latest word wins after one idle cycle
        mbox4 = 16'h1111;
        repeat (12) @(negedge clk);
        mbox4 = 16'h0001;
        repeat (4) @(negedge clk);
        mbox4 = 16'h0002;
        @(negedge clk);
        check("overrun_set", over4, 1'b1);
        gap = 0;
        while (busy4 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_idle_cycle", busy4, 1'b0);
        @(negedge clk);
        check("b2b_restart", busy4, 1'b1);
        check_word(0, vecs[1].seq, "latest_0002");
        clear4 = 1'b1;
        @(negedge clk);
        clear4 = 1'b0;
        check("overrun_clear", over4, 1'b0);
        wait_idle(50);

        // Change in the exact cycle IDLE consumes pending
        mbox4 = vecs[3].word;
        @(negedge clk);
        mbox4 = vecs[4].word;
        @(negedge clk);
        check_word(0, vecs[3].seq, "same_cycle_first");
        @(negedge clk);
        check_word(0, vecs[4].seq, "same_cycle_second");
        check("same_cycle_overrun", over4, 1'b0);
        wait_idle(50);

        // clearOverrun coincident with an overrun event
        mbox4 = 16'h3333;
        repeat (6) @(negedge clk);
        mbox4 = 16'h4444;
        @(negedge clk);
        mbox4 = 16'h5555;
        clear4 = 1'b1;
        @(negedge clk);
        clear4 = 1'b0;
        check("set_beats_clear", over4, 1'b1);
        clear4 = 1'b1;
        @(negedge clk);
        clear4 = 1'b0;
        check("clear_after_set", over4, 1'b0);
        wait_idle(400);

        // Reset during low-byte data bit 3, then full resend
        mbox4 = vecs[0].word;
        @(negedge clk);
        @(negedge clk);
        check("midreset_started", busy4, 1'b1);
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_txd", txd4, 1'b1);
        check("midreset_busy", busy4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_release_busy", busy4, 1'b0);
        @(negedge clk);
        check_word(0, vecs[0].seq, "midreset_resend");
        wait_idle(50);

        // CLKS_PER_BIT=1 boundary
        mbox1 = vecs[2].word;
        @(negedge clk);
        check("cpb1_pre_busy", busy1, 1'b0);
        @(negedge clk);
        check_word(1, vecs[2].seq, "cpb1_ff00");
        check("cpb1_overrun", over1, 1'b0);

        // Randomized run against the model
        repeat (3000) begin
            @(negedge clk);
            case ($urandom_range(0, 99))
                0, 1:    mbox4 = 16'($urandom);
                2:       mbox4 = 16'($urandom_range(0, 3));
                default: ;
            endcase
            clear4 = ($urandom_range(0, 39) == 0);
        end
        clear4 = 1'b0;
        wait_idle(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
